// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - multi-byte UART frame receiver with valid/ready output and error/timeout pulses
// Optional parity bit per character: define UART_FRAME_RX_PARITY_EN (PARITY_ODD selects odd parity).
module uart_frame_rx #(
  parameter int BYTES        = 5,
  parameter int BPS          = 9600,
  parameter int CLK_FRE      = 50_000_000,
  parameter int MSB_FIRST    = 0,
  parameter int TIMEOUT_BITS = 20
`ifdef UART_FRAME_RX_PARITY_EN
  ,
  parameter int PARITY_ODD   = 0
`endif
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               uart_rxd,
  output logic [BYTES*8-1:0] frame_data,
  output logic               frame_vld,
  input  logic               frame_rdy,
  output logic               frame_err,
  output logic               frame_timeout,
  output logic               frame_ovf
);
  localparam int BAUD_CNT = CLK_FRE / BPS;
  localparam int BW       = $clog2(BAUD_CNT + 1);
  localparam int CW       = $clog2(BYTES + 1);
  localparam int TO_CYC   = TIMEOUT_BITS * BAUD_CNT;
  localparam int TW       = $clog2(TO_CYC + 2);
  localparam logic [BW-1:0] HALF      = BW'(BAUD_CNT / 2);
  localparam logic [BW-1:0] LAST      = BW'(BAUD_CNT - 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(BYTES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state, state_nxt;
  logic               rxd_s1, rxd_s2, rxd_d, fall;
  logic [BW-1:0]      baud_cnt;
  logic               baud_clr, sample, par_smp, done_nxt, err_nxt, byte_done, par_ok;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic [CW-1:0]      byte_cnt, slot;
  logic [BYTES*8-1:0] shadow, shadow_nxt;
  logic               complete;
  logic [TW-1:0]      idle_cnt;
  logic               to_run, to_hit;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) {rxd_s1, rxd_s2, rxd_d} <= 3'b111;
    else            {rxd_s1, rxd_s2, rxd_d} <= {uart_rxd, rxd_s1, rxd_s2};
  end

  assign fall = rxd_d & ~rxd_s2;

  always_comb begin
    state_nxt = state;
    baud_clr  = 1'b0;
    sample    = 1'b0;
    par_smp   = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        baud_clr = 1'b1;
        if (fall) state_nxt = START;
      end
      START: if (baud_cnt == HALF) begin
        baud_clr  = 1'b1;
        state_nxt = rxd_s2 ? IDLE : DATA;
      end
      DATA: if (baud_cnt == LAST) begin
        baud_clr = 1'b1;
        sample   = 1'b1;
`ifdef UART_FRAME_RX_PARITY_EN
        if (bit_idx == 3'd7) state_nxt = PARITY;
`else
        if (bit_idx == 3'd7) state_nxt = STOP;
`endif
      end
`ifdef UART_FRAME_RX_PARITY_EN
      PARITY: if (baud_cnt == LAST) begin
        baud_clr  = 1'b1;
        par_smp   = 1'b1;
        state_nxt = STOP;
      end
`endif
      STOP: if (baud_cnt == LAST) begin
        // Rearm at mid-stop so a start bit directly after the stop bit is caught.
        baud_clr  = 1'b1;
        state_nxt = IDLE;
        if (rxd_s2 && par_ok) done_nxt = 1'b1;
        else                  err_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef UART_FRAME_RX_PARITY_EN
  logic par_bit;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)   par_bit <= 1'b0;
    else if (par_smp) par_bit <= rxd_s2;
  end
  assign par_ok = (par_bit == ((^shreg) ^ (PARITY_ODD != 0)));
`else
  assign par_ok = ~par_smp;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_clr ? '0 : baud_cnt + 1'b1;
      byte_done <= done_nxt;
      frame_err <= err_nxt;
      if (state == START) bit_idx <= 3'd0;
      else if (sample)    bit_idx <= bit_idx + 3'd1;
      if (sample) shreg <= {rxd_s2, shreg[7:1]};
    end
  end

  assign slot     = (MSB_FIRST != 0) ? LAST_SLOT - byte_cnt : byte_cnt;
  assign complete = byte_done && (byte_cnt == LAST_SLOT);

  always_comb begin
    shadow_nxt = shadow;
    if (byte_done) shadow_nxt[int'(slot)*8 +: 8] = shreg;
  end

  // The idle counter only runs inside a partial frame while the line is idle.
  assign to_run = (TIMEOUT_BITS != 0) && (state == IDLE) && (byte_cnt != '0) && !fall;
  assign to_hit = to_run && (idle_cnt == TO_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      byte_cnt      <= '0;
      shadow        <= '0;
      idle_cnt      <= '0;
      frame_timeout <= 1'b0;
      frame_data    <= '0;
      frame_vld     <= 1'b0;
      frame_ovf     <= 1'b0;
    end else begin
      shadow        <= shadow_nxt;
      idle_cnt      <= (!to_run || to_hit) ? '0 : idle_cnt + 1'b1;
      frame_timeout <= to_hit;
      frame_ovf     <= complete && frame_vld && !frame_rdy;
      if (frame_err || to_hit) byte_cnt <= '0;
      else if (byte_done)      byte_cnt <= complete ? '0 : byte_cnt + 1'b1;
      if (complete && (!frame_vld || frame_rdy)) begin
        frame_data <= shadow_nxt;
        frame_vld  <= 1'b1;
      end else if (frame_vld && frame_rdy) begin
        frame_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - directed bench for uart_frame_rx (LSB-first and MSB-first instances)
module tb_uart_frame_rx;
  localparam int BAUD = 100;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n, uart_rxd, frame_rdy;
  logic [39:0] frame_data, frame_data_m;
  logic        frame_vld, frame_err, frame_timeout, frame_ovf;
  logic        vld_m, err_m, to_m, ovf_m;

  int checks = 0, errors = 0;
  int n_err = 0, n_to = 0, n_ovf = 0, n_acc = 0, n_vld = 0, n_acc_m = 0;
  logic [39:0] last_d = '0, last_m = '0;

  uart_frame_rx #(.BYTES(5), .BPS(500_000), .CLK_FRE(50_000_000), .MSB_FIRST(0), .TIMEOUT_BITS(20)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(uart_rxd),
    .frame_data(frame_data), .frame_vld(frame_vld), .frame_rdy(frame_rdy),
    .frame_err(frame_err), .frame_timeout(frame_timeout), .frame_ovf(frame_ovf));

  uart_frame_rx #(.BYTES(5), .BPS(500_000), .CLK_FRE(50_000_000), .MSB_FIRST(1), .TIMEOUT_BITS(20)) dut_m (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(uart_rxd),
    .frame_data(frame_data_m), .frame_vld(vld_m), .frame_rdy(frame_rdy),
    .frame_err(err_m), .frame_timeout(to_m), .frame_ovf(ovf_m));

  always #10 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (frame_err)     n_err++;
      if (frame_timeout) n_to++;
      if (frame_ovf)     n_ovf++;
      if (frame_vld)     n_vld++;
      if (frame_vld && frame_rdy) begin n_acc++; last_d = frame_data; end
      if (vld_m && frame_rdy)     begin n_acc_m++; last_m = frame_data_m; end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    uart_rxd = v;
    repeat (BAUD) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_FRAME_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop);
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 0; i < 5; i++) send_byte(f[i*8 +: 8], 1'b1);
  endtask

  task automatic idle_bits(input int n);
    uart_rxd = 1'b1;
    repeat (n * BAUD) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    frame_rdy = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_vld", frame_vld, 0);
    check("rst_data", frame_data, 0);
    check("rst_err", frame_err, 0);
    check("rst_timeout", frame_timeout, 0);
    check("rst_ovf", frame_ovf, 0);
    sys_rst_n = 1'b1;
    idle_bits(1);

    send_frame(40'h5544332211);
    idle_bits(2);
    check("f1_acc", n_acc, 1);
    check("f1_vld_cycles", n_vld, 1);
    check("f1_data_lsb", last_d, 40'h5544332211);
    check("f1_acc_msb", n_acc_m, 1);
    check("f1_data_msb", last_m, 40'h1122334455);
    check("f1_vld_clear", frame_vld, 0);

    frame_rdy = 1'b0;
    send_frame(40'h0504030201);
    send_frame(40'h0A09080706);
    idle_bits(1);
    check("ovf_count", n_ovf, 1);
    check("ovf_vld_held", frame_vld, 1);
    check("ovf_data_held", frame_data, 40'h0504030201);
    check("ovf_no_accept", n_acc, 1);
    frame_rdy = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    check("ovf_acc", n_acc, 2);
    check("ovf_acc_data", last_d, 40'h0504030201);
    check("ovf_vld_clear", frame_vld, 0);

    send_byte(8'h77, 1'b1);
    send_byte(8'h78, 1'b1);
    idle_bits(19);
    check("to_before", n_to, 0);
    idle_bits(2);
    check("to_fired", n_to, 1);
    send_frame(40'hA4A3A2A1A0);
    idle_bits(1);
    check("to_next_acc", n_acc, 3);
    check("to_next_data", last_d, 40'hA4A3A2A1A0);
    check("to_next_msb", last_m, 40'hA0A1A2A3A4);
    check("to_no_err", n_err, 0);

    send_byte(8'hEE, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'h5A, 1'b0);
    idle_bits(2);
    check("stop_err", n_err, 1);
    uart_rxd = 1'b0;
    repeat (30) @(posedge sys_clk);
    #1;
    idle_bits(3);
    check("glitch_no_err", n_err, 1);
    check("err_no_timeout", n_to, 1);
    send_frame(40'hC5C4C3C2C1);
    idle_bits(1);
    check("err_next_acc", n_acc, 4);
    check("err_next_data", last_d, 40'hC5C4C3C2C1);
    check("err_ovf_total", n_ovf, 1);

`ifdef UART_FRAME_RX_PARITY_EN
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i < 2);
    send_bit(1'b1);
    send_bit(1'b1);
    idle_bits(1);
    check("par_bad_err", n_err, 2);
    send_frame(40'h4030201003);
    idle_bits(1);
    check("par_good_acc", n_acc, 5);
    check("par_good_data", last_d, 40'h4030201003);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Multi-byte UART frame receiver with a built-in bit-level receiver. It assembles `BYTES` consecutive bytes into one word and delivers it on a valid/ready handshake. Partial frames are discarded after an inter-byte timeout or on a line error. It sits between the board `uart_rxd` pin and user logic and replaces the fixed-length, pulse-only multi-byte receiver in designs that need backpressure, error reporting or resynchronisation.

## Interface
Parameters:
- `BYTES`, 5: bytes per frame, 1..64.
- `BPS`, 9600: baud rate.
- `CLK_FRE`, 50_000_000: `sys_clk` frequency in Hz. `BAUD_CNT = CLK_FRE/BPS` (integer division).
- `MSB_FIRST`, 0: byte order. 0 places the first received byte in `[7:0]`. 1 places the first received byte in `[BYTES*8-1 -: 8]`.
- `TIMEOUT_BITS`, 20: idle bit-times after a byte, inside a partial frame, before that partial frame is discarded. 0 disables the timeout.

Ports:
- `sys_clk`  in  1  system clock; the only clock.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `uart_rxd`  in  1  UART serial input, asynchronous, idle high.
- `frame_data`  out  BYTES*8  assembled frame; stable while `frame_vld`=1.
- `frame_vld`  out  1  frame available; held until accepted.
- `frame_rdy`  in  1  consumer accepts when `frame_vld & frame_rdy`.
- `frame_err`  out  1  1-cycle pulse: stop-bit, start-glitch-free framing or parity error; current partial frame dropped.
- `frame_timeout`  out  1  1-cycle pulse: partial frame dropped by timeout.
- `frame_ovf`  out  1  1-cycle pulse: completed frame dropped because output still full.

## Operation
- Input sync: 2-flop synchroniser on `uart_rxd`. The synchronised signal resets to 1.
- Bit FSM states:
  - IDLE: a falling edge of the synced line goes to START with the baud counter cleared.
  - START: at `BAUD_CNT/2`, if the line is still 0, go to DATA. Otherwise go back to IDLE (glitch, no error).
  - DATA: sample each bit every `BAUD_CNT` cycles, 8 bits, LSB first. After bit 7, go to PARITY (when enabled) or STOP.
  - PARITY: sample one bit and compare it against the parity computed over the 8 data bits.
  - STOP: sample at mid-bit. If the sample is 1 and parity is OK, emit an internal byte-done. Otherwise assert `frame_err`, clear the byte count and discard the partial frame. Return to IDLE in both cases, so the receiver rearms at mid-stop.
- Frame assembly:
  - On each byte-done, write the byte into slot `byte_cnt` of a shadow register according to `MSB_FIRST`, then increment `byte_cnt`.
  - When `byte_cnt == BYTES-1` and a byte-done occurs, the frame is complete and `byte_cnt` wraps to 0.
- Output register (one entry):
  - On completion with the output empty, or with `frame_vld & frame_rdy` in the same cycle, load `frame_data` and set `frame_vld`.
  - On completion with `frame_vld=1 & frame_rdy=0`, drop the new frame and pulse `frame_ovf`. `frame_data` is left unchanged.
  - `frame_vld` clears on `frame_vld & frame_rdy` unless it is reloaded in that same cycle.
- Timeout:
  - The idle counter counts `sys_clk` cycles while `byte_cnt != 0` and the bit FSM is in IDLE.
  - It is cleared on any start detection.
  - When it reaches `TIMEOUT_BITS*BAUD_CNT`, clear `byte_cnt` and pulse `frame_timeout`. `frame_vld` is not affected.
- Simultaneous events: a byte error and a timeout cannot coincide, because the timeout only runs in IDLE. An error discards only the partial frame and never affects a frame already held in the output register.

## Timing
- Reset values: `frame_data`=0, `frame_vld`=0, `frame_err`=0, `frame_timeout`=0, `frame_ovf`=0. All counters are 0 and the FSM is in IDLE. Reset mid-byte or mid-frame discards everything.
- Sampling: a falling edge on the pin is seen 2 cycles later. Sample points fall at `BAUD_CNT/2 + k*BAUD_CNT` after the start is detected.
- Latency: byte-done is registered 1 cycle after the mid-stop sample. `frame_vld` rises 1 cycle after the final byte-done.
- Pulses (`frame_err`, `frame_timeout`, `frame_ovf`) are exactly 1 cycle and registered.
- Back-to-back frames are supported with zero idle between stop and the next start, provided the consumer accepts within one byte time.

## Configuration
- `UART_FRAME_RX_PARITY_EN` defined:
  - The PARITY state is present, so each character is 11 bits.
  - Parameter `PARITY_ODD` (default 0) selects odd (1) or even (0) parity.
  - A parity mismatch pulses `frame_err`.
- Not defined: no parity state, 10-bit characters, and `PARITY_ODD` is ignored.

## Test plan
- `BYTES`=5, `MSB_FIRST`=0, `CLK_FRE`=50M, `BPS`=115200 (`BAUD_CNT`=434). Send 0x11,0x22,0x33,0x44,0x55 with `frame_rdy`=1 → `frame_vld` for 1 cycle, `frame_data`=0x5544332211.
- Same bytes with `MSB_FIRST`=1 → `frame_data`=0x1122334455.
- Hold `frame_rdy`=0 and send two full frames → first frame held, `frame_ovf` pulses once. Raise `frame_rdy` → `frame_data` is the first frame.
- Send 2 bytes, then idle for 21 bit-times → `frame_timeout` pulse. Next 5 bytes 0xA0..0xA4 → `frame_data`=0xA4A3A2A1A0.
- Send a byte with stop bit 0, and separately a 100-cycle low glitch on the line → one `frame_err` for the bad stop. Glitch ignored with no pulse. Following full frame received correctly.
- With `UART_FRAME_RX_PARITY_EN`, `PARITY_ODD`=0: send 0x03 with parity bit 1 → `frame_err`. With parity bit 0 → byte accepted.
